// File: rtl/char_write_sched.sv
// Schedules host character writes into per-row buffers, issuing them only during vertical
// blanking; also performs a full-screen blank sweep on request.
module char_write_sched #(
  parameter int unsigned NUM_ROWS   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BLANK_Y    = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_row,
  input  logic [3:0]          req_col,
  input  logic [5:0]          req_char,
  input  logic                clear_req,
  input  logic [8:0]          ycoor,
  output logic [NUM_ROWS-1:0] wr_en,
  output logic [3:0]          wr_col,
  output logic [5:0]          wr_char,
  output logic                busy,
  output logic                err_drop
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CLR_TOTAL = NUM_ROWS * 16;
  localparam int unsigned CW        = $clog2(CLR_TOTAL + 1);
  localparam logic [NUM_ROWS-1:0] ROW0 = NUM_ROWS'(1);

  typedef enum logic [1:0] {StIdle, StWaitBlank, StWrite, StClear} state_t;

  state_t        state;
  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] clr_cnt;

  logic        blank, fifo_full, fifo_empty, push, pop;
  logic [12:0] head;
  logic [2:0]  head_row;

  assign blank      = 32'(ycoor) >= BLANK_Y;
  assign fifo_full  = count == (AW + 1)'(FIFO_DEPTH);
  assign fifo_empty = count == '0;
  assign req_ready  = !fifo_full && (state != StClear);
  // A clear in the same cycle discards the incoming request as well.
  assign push       = req_valid && req_ready && !clear_req;
  assign pop        = (state == StWrite) && blank && !fifo_empty && !clear_req;
  assign head       = mem[rd_ptr];
  assign head_row   = head[12:10];
  assign busy       = !fifo_empty || (state == StClear);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_row, req_col, req_char};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      clr_cnt  <= '0;
      wr_en    <= '0;
      wr_col   <= '0;
      wr_char  <= '0;
      err_drop <= 1'b0;
    end else begin
      wr_en    <= '0;
      err_drop <= 1'b0;
      if (clear_req) begin
        state   <= StClear;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        clr_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        case (state)
          StIdle, StWaitBlank: begin
            if (!fifo_empty) state <= blank ? StWrite : StWaitBlank;
          end
          StWrite: begin
            if (fifo_empty) begin
              state <= StIdle;
            end else if (!blank) begin
              state <= StWaitBlank;
            end else begin
              if (32'(head_row) < NUM_ROWS) wr_en <= ROW0 << head_row;
              else err_drop <= 1'b1;
              wr_col  <= head[9:6];
              wr_char <= head[5:0];
            end
          end
          StClear: begin
            // The extra terminal count keeps the last sweep strobe inside CLEAR.
            if (clr_cnt == CW'(CLR_TOTAL)) begin
              state <= StIdle;
            end else if (blank) begin
              wr_en   <= ROW0 << clr_cnt[CW-1:4];
              wr_col  <= clr_cnt[3:0];
              wr_char <= 6'h3f;
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_write_sched.sv
// Randomized and directed bench for char_write_sched; a scoreboard of expected write events
// is filled from accepted requests and clears, and a monitor checks each strobe/drop in order.
module tb_char_write_sched;
  localparam int NR = 6;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, clear_req, busy, err_drop;
  logic [2:0]    req_row;
  logic [3:0]    req_col, wr_col;
  logic [5:0]    req_char, wr_char;
  logic [8:0]    ycoor;
  logic [NR-1:0] wr_en;

  int n_cmp = 0, n_fail = 0, n_strobes = 0, n_drops = 0;
  logic [13:0] exp_q[$];
  logic blank_prev = 1'b0;

  char_write_sched #(.NUM_ROWS(NR), .FIFO_DEPTH(4), .BLANK_Y(480)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_char(req_char), .clear_req(clear_req),
    .ycoor(ycoor), .wr_en(wr_en), .wr_col(wr_col), .wr_char(wr_char), .busy(busy),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted request yields one event in order; a clear discards
  // everything not yet issued and queues the full row-major blank sweep.
  always @(posedge clk) begin
    blank_prev <= (ycoor >= 9'd480);
    if (!rst_n) begin
      exp_q.delete();
    end else if (clear_req) begin
      exp_q.delete();
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, 3'(r), 4'(c), 6'h3f});
    end else if (req_valid && req_ready) begin
      if (int'(req_row) >= NR) exp_q.push_back({1'b1, 13'b0});
      else exp_q.push_back({1'b0, req_row, req_col, req_char});
    end
  end

  always @(negedge clk) begin
    logic [13:0] act, exp_e;
    int r;
    if (wr_en != '0 || err_drop) begin
      r = 0;
      for (int i = 0; i < NR; i++) if (wr_en[i]) r = i;
      if (err_drop) n_drops++;
      else n_strobes++;
      act = err_drop ? {1'b1, 13'b0} : {1'b0, 3'(r), wr_col, wr_char};
      check("single_strobe", 32'($onehot0(wr_en) && !(err_drop && wr_en != '0)), 32'd1);
      check("blank_at_issue", 32'(blank_prev), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h, expected no write", act);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_event", 32'(act), 32'(exp_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] row, input logic [3:0] col, input logic [5:0] ch);
    req_valid = 1'b1;
    req_row   = row;
    req_col   = col;
    req_char  = ch;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(busy == 1'b0 && exp_q.size() == 0) && k < bound);
    if (busy != 1'b0 || exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, expected idle", name, busy, exp_q.size());
    end
  endtask

  initial begin
    int s0, d0, hold;
    rst_n = 1'b0; req_valid = 1'b0; clear_req = 1'b0;
    req_row = '0; req_col = '0; req_char = '0; ycoor = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_drop", 32'(err_drop), 0);
    check("rst_wr_col", 32'(wr_col), 0);
    check("rst_wr_char", 32'(wr_char), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 1);

    // Single write during blank: strobe two edges after acceptance.
    ycoor = 9'd490;
    tick();
    push(3'd2, 4'd5, 6'h0a);
    @(negedge clk);
    @(negedge clk);
    check("lat_early", 32'(wr_en), 0);
    @(negedge clk);
    check("lat_wr_en", 32'(wr_en), 32'h04);
    check("lat_wr_col", 32'(wr_col), 5);
    check("lat_wr_char", 32'(wr_char), 32'h0a);
    @(negedge clk);
    check("lat_one_cycle", 32'(wr_en), 0);
    check("lat_busy", 32'(busy), 0);
    wait_idle(20, "lat");

    // Fill the FIFO outside blank, then release it.
    ycoor = 9'd100;
    tick();
    s0 = n_strobes;
    for (int i = 0; i < 4; i++) push(3'(i + 1), 4'(i * 3), 6'(i + 20));
    @(negedge clk);
    check("full_ready", 32'(req_ready), 0);
    repeat (10) tick();
    check("held_no_strobe", 32'(n_strobes), 32'(s0));
    ycoor = 9'd480;
    wait_idle(30, "full");
    check("full_strobes", 32'(n_strobes), 32'(s0 + 4));
    check("full_ready_back", 32'(req_ready), 1);

    // Blank ends after the first strobe; remaining entries wait for the next blank.
    ycoor = 9'd100;
    tick();
    s0 = n_strobes;
    push(3'd0, 4'd1, 6'h11);
    push(3'd3, 4'd2, 6'h22);
    push(3'd5, 4'd15, 6'h33);
    ycoor = 9'd480;
    tick();
    tick();
    ycoor = 9'd100;
    repeat (10) tick();
    check("split_first", 32'(n_strobes), 32'(s0 + 1));
    ycoor = 9'd500;
    wait_idle(30, "split");
    check("split_rest", 32'(n_strobes), 32'(s0 + 3));

    // Out-of-range row is dropped with a pulse.
    s0 = n_strobes;
    d0 = n_drops;
    push(3'd7, 4'd4, 6'h2a);
    wait_idle(20, "drop");
    check("drop_pulse", 32'(n_drops), 32'(d0 + 1));
    check("drop_no_strobe", 32'(n_strobes), 32'(s0));

    // Clear with queued entries: queued writes vanish, full sweep follows.
    ycoor = 9'd100;
    tick();
    push(3'd1, 4'd1, 6'h01);
    push(3'd2, 4'd2, 6'h02);
    s0 = n_strobes;
    ycoor = 9'd500;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_idle(300, "clear");
    check("clear_strobes", 32'(n_strobes), 32'(s0 + NR * 16));
    check("clear_busy", 32'(busy), 0);

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_wr_en", 32'(wr_en), 0);
    check("rst_mid_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 1);
    s0 = n_strobes;
    repeat (120) tick();
    check("rst_mid_quiet", 32'(n_strobes), 32'(s0));

    // Randomized traffic.
    hold = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (hold == 0) begin
        ycoor = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(480, 511))
                                            : 9'($urandom_range(0, 479));
        hold = $urandom_range(1, 20);
      end else begin
        hold--;
      end
      req_valid = ($urandom_range(0, 2) != 0);
      req_row   = 3'($urandom_range(0, 7));
      req_col   = 4'($urandom_range(0, 15));
      req_char  = 6'($urandom_range(0, 63));
      clear_req = ($urandom_range(0, 199) == 0);
      tick();
    end
    req_valid = 1'b0;
    clear_req = 1'b0;
    ycoor = 9'd500;
    wait_idle(400, "random_drain");
    check("final_pending", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
